r2n_buffer_o: RTL and testbench

- Ready-to-normal output buffer; the inverse of the input-side normal-to-ready reshaper.
- Accepts block-ordered result chunks from the multi-MAC matrix multiplier, one chunk word per column-block, covering BLOCK_SIZE*NUM_CORES rows (one slice).
- Reassembles each slice into full row-major rows of COL elements and streams them row by row to the downstream stage (next layer's input buffer or writeback).

---
 rtl/r2n_buffer_o.sv | 175 +++++++++++++++++
 tb/tb_r2n_buffer_o.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2n_buffer_o.sv
// r2n_buffer_o: reassembles block-ordered MAC result chunks into full row-major rows.
// Define R2N_DOUBLE_BUF_EN for ping-pong slice banks so collection overlaps draining.
module r2n_buffer_o #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 2,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 4,
    parameter int ROW        = 64,
    parameter int COL        = 64
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 en,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [WIDTH*COL-1:0]                 out_data,
    output logic [$clog2(ROW)-1:0]               out_row_idx,
    output logic                                 slice_done,
    output logic                                 buffer_done
);

    localparam int SLICE_ROWS       = BLOCK_SIZE * NUM_CORES;
    localparam int CHUNKS_PER_SLICE = COL / BLOCK_SIZE;
    localparam int NUM_SLICES       = ROW / SLICE_ROWS;
    localparam int CW  = (CHUNKS_PER_SLICE > 1) ? $clog2(CHUNKS_PER_SLICE) : 1;
    localparam int RW  = (SLICE_ROWS > 1) ? $clog2(SLICE_ROWS) : 1;
    localparam int SW  = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int IW  = $clog2(ROW);
    localparam int CLW = (COL > 1) ? $clog2(COL) : 1;
    localparam int KW  = (CHUNK_SIZE > 1) ? $clog2(CHUNK_SIZE) : 1;
    localparam int NCW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    typedef logic [COL-1:0][WIDTH-1:0] row_t;

    state_t  state, state_nxt;
    logic [CW-1:0] chunk_cnt;
    logic [RW-1:0] row_cnt;
    logic [SW-1:0] slice_cnt;
    logic wr_fire, rd_fire, last_chunk, last_row, last_slice;
    logic [NUM_CORES-1:0][CHUNK_SIZE-1:0][WIDTH-1:0] in_elems;
    row_t rd_row;

`ifdef R2N_DOUBLE_BUF_EN
    localparam int AW = $clog2(NUM_SLICES + 1);
    row_t slice_buf [2][SLICE_ROWS];
    logic          wr_bank, rd_bank;
    logic [1:0]    bank_full;
    logic [AW-1:0] acc_cnt;
`else
    row_t slice_buf [SLICE_ROWS];
`endif

    assign in_elems   = in_data;
    assign wr_fire    = in_valid & in_ready;
    assign rd_fire    = out_valid & out_ready;
    assign last_chunk = (chunk_cnt == CW'(CHUNKS_PER_SLICE - 1));
    assign last_row   = (row_cnt == RW'(SLICE_ROWS - 1));
    assign last_slice = (slice_cnt == SW'(NUM_SLICES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = COLLECT;
            end
`ifdef R2N_DOUBLE_BUF_EN
            // Both sides run concurrently here; the bank flags arbitrate ownership.
            COLLECT: begin
                in_ready  = !bank_full[wr_bank] && (acc_cnt < AW'(NUM_SLICES));
                out_valid = bank_full[rd_bank];
                if (bank_full[rd_bank] && out_ready && last_row && last_slice)
                    state_nxt = DONE;
            end
            DRAIN: begin
                state_nxt = IDLE;
            end
`else
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && last_chunk) state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && last_row) state_nxt = last_slice ? DONE : COLLECT;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counters only move on handshakes and are cleared when a new run starts.
    always_ff @(posedge clk) begin
        if (!rst_n || (state == IDLE && en)) begin
            chunk_cnt <= '0;
            row_cnt   <= '0;
            slice_cnt <= '0;
`ifdef R2N_DOUBLE_BUF_EN
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            bank_full <= '0;
            acc_cnt   <= '0;
`endif
        end else begin
            if (wr_fire) chunk_cnt <= last_chunk ? '0 : chunk_cnt + 1'b1;
            if (rd_fire) begin
                row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                if (last_row && !last_slice) slice_cnt <= slice_cnt + 1'b1;
            end
`ifdef R2N_DOUBLE_BUF_EN
            if (wr_fire && last_chunk) begin
                bank_full[wr_bank] <= 1'b1;
                wr_bank            <= ~wr_bank;
                acc_cnt            <= acc_cnt + 1'b1;
            end
            if (rd_fire && last_row) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
`endif
        end
    end

    // Scatter each core's block into its rows at column-block chunk_cnt.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int r = 0; r < BLOCK_SIZE; r++) begin
                    for (int k = 0; k < BLOCK_SIZE; k++) begin
`ifdef R2N_DOUBLE_BUF_EN
                        slice_buf[wr_bank][RW'(c*BLOCK_SIZE + r)]
                                 [CLW'(COL - 1 - (int'(chunk_cnt)*BLOCK_SIZE + k))]
                            <= in_elems[NCW'(NUM_CORES-1-c)][KW'(CHUNK_SIZE-1-(r*BLOCK_SIZE+k))];
`else
                        slice_buf[RW'(c*BLOCK_SIZE + r)]
                                 [CLW'(COL - 1 - (int'(chunk_cnt)*BLOCK_SIZE + k))]
                            <= in_elems[NCW'(NUM_CORES-1-c)][KW'(CHUNK_SIZE-1-(r*BLOCK_SIZE+k))];
`endif
                    end
                end
            end
        end
    end

`ifdef R2N_DOUBLE_BUF_EN
    assign rd_row = slice_buf[rd_bank][row_cnt];
`else
    assign rd_row = slice_buf[row_cnt];
`endif

    // Outputs read as zero whenever no row is being presented.
    assign out_data    = out_valid ? rd_row : '0;
    assign out_row_idx = out_valid ? IW'(32'(slice_cnt) * 32'(SLICE_ROWS) + 32'(row_cnt)) : '0;
    assign slice_done  = rd_fire & last_row;
    assign buffer_done = (state == DONE);

endmodule

// File: tb/tb_r2n_buffer_o.sv
// tb_r2n_buffer_o: scoreboard bench for r2n_buffer_o on an 8x4 matrix, 2 cores, 2x2 blocks.
// Honours R2N_DOUBLE_BUF_EN when the bench is built with the same define as the RTL.
module tb_r2n_buffer_o;

    localparam int WIDTH      = 16;
    localparam int BLOCK_SIZE = 2;
    localparam int CHUNK_SIZE = 4;
    localparam int NUM_CORES  = 2;
    localparam int ROW        = 8;
    localparam int COL        = 4;
    localparam int SLICE_ROWS = BLOCK_SIZE * NUM_CORES;
    localparam int IN_W       = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int OUT_W      = WIDTH * COL;
`ifdef R2N_DOUBLE_BUF_EN
    localparam bit DB_BUILD = 1'b1;
`else
    localparam bit DB_BUILD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_row_idx;
    logic             slice_done;
    logic             buffer_done;

    typedef struct {
        int               idx;
        logic [OUT_W-1:0] data;
    } exp_row_t;

    exp_row_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int hs_cycle = -10;
    int hs_idx = -1;
    int row3_cycle = -10;
    bit check_bubble = 1'b0;

    r2n_buffer_o #(
        .WIDTH(WIDTH), .BLOCK_SIZE(BLOCK_SIZE), .CHUNK_SIZE(CHUNK_SIZE),
        .NUM_CORES(NUM_CORES), .ROW(ROW), .COL(COL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row_idx(out_row_idx), .slice_done(slice_done), .buffer_done(buffer_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [OUT_W-1:0] act,
                                input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Element value is row*COL+col; column 0 sits at the MSB.
    function automatic logic [OUT_W-1:0] row_word(input int r);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int col = 0; col < COL; col++)
            w[(COL-1-col)*WIDTH +: WIDTH] = 16'(r*COL + col);
        return w;
    endfunction

    function automatic logic [IN_W-1:0] chunk_word(input int s, input int j);
        logic [IN_W-1:0] w;
        w = '0;
        for (int c = 0; c < NUM_CORES; c++)
            for (int r = 0; r < BLOCK_SIZE; r++)
                for (int k = 0; k < BLOCK_SIZE; k++)
                    w[((NUM_CORES-1-c)*CHUNK_SIZE + CHUNK_SIZE-1-(r*BLOCK_SIZE+k))*WIDTH +: WIDTH]
                        = 16'((s*SLICE_ROWS + c*BLOCK_SIZE + r)*COL + j*BLOCK_SIZE + k);
        return w;
    endfunction

    task automatic check_idle(input string tag);
        check_output({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, "_out_data"}, out_data, 64'd0);
        check_output({tag, "_out_row_idx"}, 64'(out_row_idx), 64'd0);
        check_output({tag, "_slice_done"}, 64'(slice_done), 64'd0);
        check_output({tag, "_buffer_done"}, 64'(buffer_done), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every row handshake, independent of stimulus.
    always @(negedge clk) begin
        exp_row_t e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_row actual=%0d required=none", out_row_idx);
            end else begin
                e = exp_q.pop_front();
                check_output("row_idx", 64'(out_row_idx), 64'(e.idx));
                check_output("row_data", out_data, e.data);
                check_output("slice_done_hs", 64'(slice_done), 64'((e.idx % SLICE_ROWS) == SLICE_ROWS-1));
                if (check_bubble && e.idx == SLICE_ROWS)
                    check_output("no_bubble", 64'(cyc - row3_cycle), 64'd1);
                if (e.idx == SLICE_ROWS-1) row3_cycle = cyc;
                if (DB_BUILD && e.idx < 2)
                    check_output("in_ready_overlap", 64'(in_ready), 64'd1);
                hs_cycle = cyc;
                hs_idx   = e.idx;
            end
        end else begin
            check_output("slice_done_idle", 64'(slice_done), 64'd0);
        end
        if (buffer_done) begin
            done_cnt++;
            check_output("buffer_done_timing", 64'((cyc - hs_cycle == 1) && (hs_idx == ROW-1)), 64'd1);
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_output("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic apply_stimulus(input bit gaps);
        for (int s = 0; s < ROW/SLICE_ROWS; s++) begin
            for (int j = 0; j < COL/BLOCK_SIZE; j++) begin
                in_valid = 1'b1;
                in_data  = chunk_word(s, j);
                wait_ready();
                tick();
                if (gaps) begin
                    in_valid = 1'b0;
                    in_data  = '1;
                    tick();
                    // Junk offered while the single bank drains must never land.
                    if (!DB_BUILD && s == 0 && j == COL/BLOCK_SIZE-1) begin
                        in_valid = 1'b1;
                        tick();
                        tick();
                    end
                end
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic drive_ready(input bit bp);
        int n;
        out_ready = 1'b1;
        if (bp) begin
            n = 0;
            while (!(out_valid && out_row_idx == 3'd2) && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) check_output("row2_timeout", 64'(out_row_idx), 64'd2);
            out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                check_output("bp_hold_idx", 64'(out_row_idx), 64'd2);
                check_output("bp_hold_data", out_data, row_word(2));
                check_output("bp_hold_valid", 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
        end
    endtask

    task automatic run_matrix(input bit gaps, input bit bp, input bit bubble);
        exp_row_t e;
        int start_done;
        int n;
        check_bubble = bubble;
        for (int r = 0; r < ROW; r++) begin
            e.idx  = r;
            e.data = row_word(r);
            exp_q.push_back(e);
        end
        start_done = done_cnt;
        en = 1'b1;
        tick();
        en = 1'b0;
        fork
            apply_stimulus(gaps);
            drive_ready(bp);
        join
        n = 0;
        while (done_cnt == start_done && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        check_output("buffer_done_count", 64'(done_cnt - start_done), 64'd1);
        check_output("rows_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check_bubble = 1'b0;
    endtask

    initial begin
        $display("[TB] start, double buffer build = %0d", DB_BUILD);
        tick();
        tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("idle");

        run_matrix(1'b0, 1'b0, DB_BUILD);

        en = 1'b1;
        tick();
        en = 1'b0;
        in_valid = 1'b1;
        in_data  = chunk_word(0, 0);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check_idle("mid_reset");
        rst_n = 1'b1;
        tick();
        tick();
        check_idle("post_reset");

        run_matrix(1'b0, 1'b0, 1'b0);
        run_matrix(1'b1, 1'b0, 1'b0);
        run_matrix(1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
